itcm_port_arbiter: RTL and testbench

- Shares the single-port instruction TCM between two requesters: instruction fetch (reads only) and the MEMEX-stage load/store unit (reads and writes, where itcm_we_MEMEX is set).
- Arbitrates between the two each cycle, gives the LSU priority, and bounds fetch starvation.
- Performs sub-word stores as a two-cycle read-modify-write, because the ITCM macro has no byte enables.
- Sits between the fetch stage, the MEMEX stage and the ITCM. Its grant signals drive the stall logic.

---
 rtl/tcm_pkg.sv | 66 ++++++
 rtl/itcm_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_itcm_port_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_pkg.sv
// Shared ITCM access types: data-width encoding, arbiter states and the
// byte/half merge used by the read-modify-write store path.
package tcm_pkg;

   // Access width as carried by the LSU and decoder; 2'b11 is treated as word.
   typedef enum logic [1:0] {
      WIDTH_BYTE = 2'b00,
      WIDTH_HALF = 2'b01,
      WIDTH_WORD = 2'b10
   } width_e;

   // ITCM port arbiter states.
   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_RMW_WR = 1'b1
   } arb_state_e;

   // Word and the reserved 2'b11 encoding both access a full word.
   function automatic logic is_word(input logic [1:0] width);
      return width[1];
   endfunction

   // Half-words need an even byte address, words a 4-byte aligned one.
   function automatic logic is_misaligned(
      input logic [1:0] width,
      input logic [1:0] off
   );
      logic bad;
      bad = 1'b0;
      if (width[1]) begin
         bad = (off != 2'b00);
      end else if (width == WIDTH_HALF) begin
         bad = off[0];
      end
      return bad;
   endfunction

   // Insert the low byte or half of data into word at byte offset off.
   // For halves only off[1] matters; alignment is checked beforehand.
   function automatic logic [31:0] merge_subword(
      input logic [31:0] word,
      input logic [15:0] data,
      input logic        half,
      input logic [1:0]  off
   );
      logic [31:0] m;
      m = word;
      if (half) begin
         if (off[1]) begin
            m[31:16] = data;
         end else begin
            m[15:0] = data;
         end
      end else begin
         unique case (off)
            2'd0: m[7:0]   = data[7:0];
            2'd1: m[15:8]  = data[7:0];
            2'd2: m[23:16] = data[7:0];
            2'd3: m[31:24] = data[7:0];
            default: m = word;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/itcm_port_arbiter.sv
// Shares the single-port ITCM between instruction fetch and the LSU.
// LSU has priority; fetch wins once it has been denied STARVE_LIMIT
// consecutive cycles. Sub-word stores run as a two-cycle read-modify-write
// because the ITCM macro has no byte enables.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   fetch_req/addr     fetch request and byte address
//   fetch_gnt          fetch accepted this cycle (combinational)
//   fetch_rvalid/rdata fetch data, one cycle after the grant
//   lsu_req/we/addr    LSU request, store flag, byte address
//   lsu_wdata/width    right-aligned store data, access width
//   lsu_gnt            LSU accepted this cycle (combinational)
//   lsu_done/rdata     load data valid or store committed (registered)
//   lsu_misaligned     misaligned request rejected (registered pulse)
//   itcm_*             ITCM macro port
module itcm_port_arbiter
   import tcm_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [31:0]       fetch_rdata,
   input  logic              lsu_req,
   input  logic              lsu_we,
   input  logic [31:0]       lsu_addr,
   input  logic [31:0]       lsu_wdata,
   input  logic [1:0]        lsu_width,
   output logic              lsu_gnt,
   output logic              lsu_done,
   output logic [31:0]       lsu_rdata,
   output logic              lsu_misaligned,
   output logic              itcm_en,
   output logic              itcm_we,
   output logic [ADDR_W-1:0] itcm_addr,
   output logic [31:0]       itcm_wdata,
   input  logic [31:0]       itcm_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_e        state;
   arb_state_e        next_state;
   logic [CNT_W-1:0]  starve_cnt;
   logic              starve_hit;

   logic [ADDR_W-1:0] fetch_word;
   logic [ADDR_W-1:0] lsu_word;
   logic              lsu_bad;
   logic              lsu_acc;
   logic              lsu_sub;
   logic              fetch_wins;
   logic              lsu_commit;
   logic              rmw_start;

   logic [ADDR_W-1:0] rmw_addr;
   logic [15:0]       rmw_data;
   logic              rmw_half;
   logic [1:0]        rmw_off;

   logic              unused_addr_bits;

   assign fetch_word = fetch_addr[ADDR_W+1:2];
   assign lsu_word   = lsu_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{fetch_addr[31:ADDR_W+2],
                               fetch_addr[1:0],
                               lsu_addr[31:ADDR_W+2]};

   assign lsu_bad    = lsu_req && is_misaligned(lsu_width, lsu_addr[1:0]);
   assign lsu_acc    = lsu_req && !lsu_bad;
   assign lsu_sub    = lsu_we && !is_word(lsu_width);
   assign starve_hit = (starve_cnt >= CNT_MAX);

   // Both requesters see the same ITCM output; only the valid differs.
   assign fetch_rdata = itcm_rdata;
   assign lsu_rdata   = itcm_rdata;

   always_comb begin
      next_state = state;
      fetch_gnt  = 1'b0;
      lsu_gnt    = 1'b0;
      fetch_wins = 1'b0;
      itcm_en    = 1'b0;
      itcm_we    = 1'b0;
      itcm_addr  = fetch_word;
      itcm_wdata = lsu_wdata;
      if (!rst) begin
         unique case (state)
            ARB_IDLE: begin
               // A misaligned LSU request never touches the port,
               // so it cannot block fetch.
               fetch_wins = fetch_req && (!lsu_acc || starve_hit);
               fetch_gnt  = fetch_wins;
               lsu_gnt    = lsu_bad || (lsu_acc && !fetch_wins);
               if (fetch_wins) begin
                  itcm_en   = 1'b1;
                  itcm_addr = fetch_word;
               end else if (lsu_acc) begin
                  itcm_en   = 1'b1;
                  itcm_we   = lsu_we && !lsu_sub;
                  itcm_addr = lsu_word;
                  if (lsu_sub) begin
                     next_state = ARB_RMW_WR;
                  end
               end
            end
            ARB_RMW_WR: begin
               itcm_en    = 1'b1;
               itcm_we    = 1'b1;
               itcm_addr  = rmw_addr;
               itcm_wdata = merge_subword(itcm_rdata, rmw_data,
                                          rmw_half, rmw_off);
               next_state = ARB_IDLE;
            end
            default: next_state = ARB_IDLE;
         endcase
      end
   end

   assign lsu_commit = lsu_gnt && lsu_acc && !lsu_sub;
   assign rmw_start  = lsu_gnt && lsu_acc && lsu_sub;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ARB_IDLE;
         starve_cnt     <= '0;
         fetch_rvalid   <= 1'b0;
         lsu_done       <= 1'b0;
         lsu_misaligned <= 1'b0;
      end else begin
         state          <= next_state;
         fetch_rvalid   <= fetch_gnt;
         lsu_done       <= lsu_commit || (state == ARB_RMW_WR);
         lsu_misaligned <= lsu_gnt && lsu_bad;
         if (fetch_gnt) begin
            starve_cnt <= '0;
         end else if (fetch_req && !starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end

   // Latched store context for the write half of the RMW.
   always_ff @(posedge clk) begin
      if (rmw_start) begin
         rmw_addr <= lsu_word;
         rmw_data <= lsu_wdata[15:0];
         rmw_half <= (lsu_width == WIDTH_HALF);
         rmw_off  <= lsu_addr[1:0];
      end
   end

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// Self-checking bench for itcm_port_arbiter: transaction-level model of the
// arbitration rules and ITCM contents, with a queue-based response monitor.
module tb_itcm_port_arbiter;

   localparam int AW = 12;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fetch_req = 1'b0;
   logic [31:0]   fetch_addr = '0;
   logic          fetch_gnt;
   logic          fetch_rvalid;
   logic [31:0]   fetch_rdata;
   logic          lsu_req = 1'b0;
   logic          lsu_we = 1'b0;
   logic [31:0]   lsu_addr = '0;
   logic [31:0]   lsu_wdata = '0;
   logic [1:0]    lsu_width = 2'b10;
   logic          lsu_gnt;
   logic          lsu_done;
   logic [31:0]   lsu_rdata;
   logic          lsu_misaligned;
   logic          itcm_en;
   logic          itcm_we;
   logic [AW-1:0] itcm_addr;
   logic [31:0]   itcm_wdata;
   logic [31:0]   itcm_rdata;

   always #5 clk = ~clk;

   itcm_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
      .fetch_rdata(fetch_rdata),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_width(lsu_width),
      .lsu_gnt(lsu_gnt), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
      .lsu_misaligned(lsu_misaligned),
      .itcm_en(itcm_en), .itcm_we(itcm_we), .itcm_addr(itcm_addr),
      .itcm_wdata(itcm_wdata), .itcm_rdata(itcm_rdata)
   );

   // ITCM macro: synchronous, one-cycle read latency, no byte enables.
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (itcm_en) begin
         if (itcm_we) mem[itcm_addr] <= itcm_wdata;
         else itcm_rdata <= mem[itcm_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        mis;
      logic        chkd;
   } rsp_t;

   rsp_t fq[$];
   rsp_t lq[$];
   rsp_t fe, le;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Reference ITCM contents after every committed store.
   logic [31:0] gold [0:4095];

   logic          f_pend, l_pend, l_we, rst_v, busy;
   logic [31:0]   f_a, l_a, l_d, p_data;
   logic [1:0]    l_w;
   logic [AW-1:0] p_addr;
   int            starve;
   logic          seen_fgnt;

   function automatic logic misal(input logic [1:0] w, input logic [1:0] o);
      if (w == 2'b00) return 1'b0;
      if (w == 2'b01) return o[0];
      return o != 2'b00;
   endfunction

   function automatic logic [31:0] tb_merge(input logic [31:0] old,
                                            input logic [31:0] d,
                                            input logic [1:0] w,
                                            input logic [1:0] o);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
      if (w == 2'b00) begin
         b[o] = d[7:0];
      end else begin
         b[{o[1], 1'b0}] = d[7:0];
         b[{o[1], 1'b1}] = d[15:8];
      end
      return {b[3], b[2], b[1], b[0]};
   endfunction

   // Monitor: every response must match the head of its queue in cycle and
   // content; a head whose due cycle passes unanswered is a miss.
   always @(negedge clk) begin
      if (fetch_rvalid === 1'b1) begin
         if (fq.size() == 0) begin
            chk("fetch_rvalid_unexpected", 1, 0);
         end else begin
            fe = fq.pop_front();
            chk("fetch_rvalid_cycle", cyc, fe.due);
            chk("fetch_rdata", fetch_rdata, fe.data);
         end
      end else if (fq.size() != 0 && fq[0].due <= cyc) begin
         chk("fetch_rvalid_missing", 0, 1);
         fq.delete(0);
      end
      if (lsu_done === 1'b1 || lsu_misaligned === 1'b1) begin
         if (lq.size() == 0) begin
            chk("lsu_rsp_unexpected", {lsu_misaligned, lsu_done}, 0);
         end else begin
            le = lq.pop_front();
            chk("lsu_rsp_cycle", cyc, le.due);
            chk("lsu_rsp_kind", {lsu_misaligned, lsu_done},
                le.mis ? 32'd2 : 32'd1);
            if (le.chkd) chk("lsu_rdata", lsu_rdata, le.data);
         end
      end else if (lq.size() != 0 && lq[0].due <= cyc) begin
         chk("lsu_rsp_missing", 0, 1);
         lq.delete(0);
      end
   end

   // One clock: drive pending requests, predict grants and port activity
   // from the arbitration rules, and queue the expected responses.
   task automatic step();
      logic ef, el, mis, freq;
      logic [AW-1:0] fw, lw;
      @(posedge clk);
      #1;
      rst        = rst_v;
      fetch_req  = f_pend;
      fetch_addr = f_a;
      lsu_req    = l_pend;
      lsu_we     = l_we;
      lsu_addr   = l_a;
      lsu_wdata  = l_d;
      lsu_width  = l_w;
      @(negedge clk);
      freq = f_pend;
      fw   = f_a[AW+1:2];
      lw   = l_a[AW+1:2];
      mis  = l_pend && misal(l_w, l_a[1:0]);
      ef   = 1'b0;
      el   = 1'b0;
      if (!rst_v && !busy) begin
         if (mis) begin
            el = 1'b1;
            ef = f_pend;
         end else if (f_pend && l_pend) begin
            if (starve >= SL) ef = 1'b1;
            else el = 1'b1;
         end else begin
            ef = f_pend;
            el = l_pend;
         end
      end
      seen_fgnt = fetch_gnt;
      chk("fetch_gnt", fetch_gnt, ef);
      chk("lsu_gnt", lsu_gnt, el);
      if (rst_v) begin
         chk("rst_itcm_en", itcm_en, 0);
         chk("rst_itcm_we", itcm_we, 0);
      end else if (busy) begin
         chk("rmw_en", itcm_en, 1);
         chk("rmw_we", itcm_we, 1);
         chk("rmw_addr", itcm_addr, p_addr);
         chk("rmw_wdata", itcm_wdata, p_data);
      end else if (ef) begin
         chk("fetch_en", itcm_en, 1);
         chk("fetch_we", itcm_we, 0);
         chk("fetch_addr", itcm_addr, fw);
      end else if (el && !mis) begin
         chk("lsu_en", itcm_en, 1);
         chk("lsu_we", itcm_we, l_we && l_w[1]);
         chk("lsu_addr", itcm_addr, lw);
         if (l_we && l_w[1]) chk("lsu_wdata", itcm_wdata, l_d);
      end else begin
         chk("idle_en", itcm_en, 0);
         chk("idle_we", itcm_we, 0);
      end
      if (rst_v) begin
         if (busy) void'(lq.pop_back());
         busy   = 1'b0;
         starve = 0;
      end else begin
         if (busy) begin
            gold[p_addr] = p_data;
            busy = 1'b0;
         end
         if (ef) begin
            fq.push_back('{cyc + 1, gold[fw], 1'b0, 1'b1});
            f_pend = 1'b0;
            starve = 0;
         end else if (freq && starve < SL) begin
            starve++;
         end
         if (el) begin
            if (mis) begin
               lq.push_back('{cyc + 1, 32'h0, 1'b1, 1'b0});
            end else if (!l_we) begin
               lq.push_back('{cyc + 1, gold[lw], 1'b0, 1'b1});
            end else if (l_w[1]) begin
               gold[lw] = l_d;
               lq.push_back('{cyc + 1, 32'h0, 1'b0, 1'b0});
            end else begin
               busy   = 1'b1;
               p_addr = lw;
               p_data = tb_merge(gold[lw], l_d, l_w, l_a[1:0]);
               lq.push_back('{cyc + 2, 32'h0, 1'b0, 1'b0});
            end
            l_pend = 1'b0;
         end
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) << 16);
      if ($urandom_range(0, 1) == 1) a = a | $urandom_range(0, 3);
      return a;
   endfunction

   initial begin
      logic [31:0] v;
      int mism;
      int first_f;
      for (int i = 0; i < 4096; i++) begin
         v = $urandom;
         mem[i] <= v;
         gold[i] = v;
      end
      mem[16'h10] <= 32'hDEADBEEF;
      gold[16'h10] = 32'hDEADBEEF;
      mem[16'h40] <= 32'h11223344;
      gold[16'h40] = 32'h11223344;
      busy = 1'b0; starve = 0;
      f_pend = 1'b1; f_a = 32'h40;
      l_pend = 1'b0; l_we = 1'b0; l_a = 0; l_d = 0; l_w = 2'b10;

      // Reset with fetch already requesting: no grants, outputs low.
      rst_v = 1'b1;
      step();
      step();
      chk("reset_fetch_rvalid", fetch_rvalid, 0);
      chk("reset_lsu_done", lsu_done, 0);
      chk("reset_lsu_misaligned", lsu_misaligned, 0);
      rst_v = 1'b0;

      // Fetch 0x40 reads word 0x10 (0xDEADBEEF).
      step();
      step();

      // Simultaneous fetch and load at 0x80: LSU first, fetch next.
      f_pend = 1'b1; f_a = 32'h200;
      l_pend = 1'b1; l_we = 1'b0; l_a = 32'h80; l_w = 2'b10;
      step();
      step();
      step();

      // Byte store 0xAB at 0x103 over 0x11223344, fetch waiting.
      f_pend = 1'b1; f_a = 32'h4;
      l_pend = 1'b1; l_we = 1'b1; l_a = 32'h103; l_d = 32'hAB; l_w = 2'b00;
      step();
      step();
      step();
      step();
      chk("rmw_byte_result", mem[16'h40], 32'hAB223344);

      // Continuous fetch and loads: fetch wins on the fifth cycle.
      first_f = -1;
      for (int i = 0; i < 12; i++) begin
         if (!f_pend) begin f_pend = 1'b1; f_a = rnd_addr(); end
         if (!l_pend) begin
            l_pend = 1'b1; l_we = 1'b0; l_w = 2'b10;
            l_a = rnd_addr() & 32'hFFFF_FFFC;
         end
         step();
         if (seen_fgnt === 1'b1 && first_f < 0) first_f = i;
      end
      chk("starve_first_fetch_grant", first_f, 4);
      f_pend = 1'b0;
      l_pend = 1'b0;
      step();
      step();

      // Misaligned half store at 0x101 alongside a fetch.
      f_pend = 1'b1; f_a = 32'h8;
      l_pend = 1'b1; l_we = 1'b1; l_a = 32'h101; l_d = 32'h5555; l_w = 2'b01;
      step();
      step();

      // Reset during the RMW write cycle abandons the store.
      l_pend = 1'b1; l_we = 1'b1; l_a = 32'h20; l_d = 32'h77; l_w = 2'b00;
      step();
      rst_v = 1'b1;
      step();
      rst_v = 1'b0;
      step();
      chk("rmw_reset_done", lsu_done, 0);
      chk("rmw_reset_rvalid", fetch_rvalid, 0);
      chk("rmw_reset_mis", lsu_misaligned, 0);
      chk("rmw_reset_no_write", mem[8], gold[8]);

      // Randomised traffic, including rare resets.
      for (int i = 0; i < 3000; i++) begin
         if (!f_pend && $urandom_range(0, 3) != 0) begin
            f_pend = 1'b1;
            f_a = rnd_addr();
         end
         if (!l_pend && $urandom_range(0, 2) != 0) begin
            l_pend = 1'b1;
            l_we = $urandom_range(0, 1);
            l_w = $urandom_range(0, 3);
            l_a = rnd_addr();
            l_d = $urandom;
         end
         rst_v = ($urandom_range(0, 399) == 0);
         step();
      end
      rst_v = 1'b0;
      f_pend = 1'b0;
      l_pend = 1'b0;
      for (int i = 0; i < 4; i++) step();

      chk("fetch_queue_drained", fq.size(), 0);
      chk("lsu_queue_drained", lq.size(), 0);
      mism = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== gold[i]) mism++;
      chk("final_memory_image", mism, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
